// File: rtl/sum_bcd_converter.sv
// Binary-to-packed-BCD converter (iterative double-dabble, one bit per cycle) with
// valid/ready handshakes on both sides. Optional 7-segment output behind SEVEN_SEG_EN.
module sum_bcd_converter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef SEVEN_SEG_EN
    output logic [7*DIGITS-1:0]   seg,
`endif
    output logic                  busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned BW = 4 * DIGITS;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e         state_q;
    logic [CW-1:0]  count_q;
    logic [WIDTH-1:0] bin_q;
    logic [BW-1:0]  dig_q;

    logic [BW-1:0]    dig_adj;
    logic [BW-1:0]    dig_next;
    logic [WIDTH-1:0] bin_next;

    // Add-3 correction first, then shift the combined {digits, binary} register left.
    always_comb begin
        dig_adj = dig_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (dig_q[4*i +: 4] >= 4'd5) begin
                dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
            end
        end
        {dig_next, bin_next} = {dig_adj, bin_q} << 1;
    end

`ifdef SEVEN_SEG_EN
    localparam logic [7*DIGITS-1:0] SegRst = (7*DIGITS)'(7'h3F);

    logic [7*DIGITS-1:0] seg_next;
    logic                leading;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Blank zero digits above the most significant nonzero one; ones is always shown.
    always_comb begin
        seg_next = '0;
        leading  = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (dig_next[4*i +: 4] != 4'd0 || i == 0) begin
                leading = 1'b0;
            end
            seg_next[7*i +: 7] = leading ? 7'h00 : seg_decode(dig_next[4*i +: 4]);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            bin_q     <= '0;
            dig_q     <= '0;
            bcd       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef SEVEN_SEG_EN
            seg       <= SegRst;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        bin_q    <= bin;
                        dig_q    <= '0;
                        count_q  <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    bin_q   <= bin_next;
                    dig_q   <= dig_next;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        bcd       <= dig_next;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
`ifdef SEVEN_SEG_EN
                        seg       <= seg_next;
`endif
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
